// File: rtl/uart_rx_fifo_if.sv
// Bus-side signal bundle for uart_rx_fifo: serial input, FIFO read port, status and error flags.
// The slave modport is the receiver; the master modport is whatever drives rx and reads the FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned FIFO_DEPTH_BITS = 4
);
    logic                     rx;
    logic [DATA_BITS-1:0]     data;
    logic                     rd;
    logic [FIFO_DEPTH_BITS:0] count;
    logic                     empty;
    logic                     full;
    logic                     parity_error;
    logic                     framing_error;
    logic                     overflow;
    logic                     error_clear;
    logic                     interrupt;

    modport slave (
        input  rx, rd, error_clear,
        output data, count, empty, full, parity_error, framing_error, overflow, interrupt
    );

    modport master (
        output rx, rd, error_clear,
        input  data, count, empty, full, parity_error, framing_error, overflow, interrupt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, start-bit glitch rejection, sticky error flags
// and a show-ahead RX FIFO with a level interrupt.
`ifndef UART_CLOCK_DIV
`define UART_CLOCK_DIV 16
`endif
`ifndef UART_CLOCK_COUNTER_BITS
`define UART_CLOCK_COUNTER_BITS 4
`endif

module uart_rx_fifo #(
    parameter int unsigned CLOCK_DIV          = `UART_CLOCK_DIV,
    parameter int unsigned CLOCK_COUNTER_BITS = `UART_CLOCK_COUNTER_BITS,
    parameter int unsigned DATA_BITS          = 8,
    parameter int unsigned PARITY             = 0,
    parameter int unsigned STOP_BITS          = 1,
    parameter int unsigned FIFO_DEPTH_BITS    = 4,
    parameter int unsigned IRQ_LEVEL          = 1
) (
    input logic           clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int unsigned CW    = CLOCK_COUNTER_BITS;
    localparam int unsigned NW    = FIFO_DEPTH_BITS + 1;

    localparam logic [CW-1:0] HalfLast = CW'(CLOCK_DIV / 2 - 1);
    localparam logic [CW-1:0] BitLast  = CW'(CLOCK_DIV - 1);
    localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);
    localparam logic [NW-1:0] DepthVal = NW'(DEPTH);
    localparam logic [NW-1:0] IrqVal   = NW'(IRQ_LEVEL);

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                    state_q, state_d;
    logic                      rx_meta_q, rx_s_q;
    logic [CW-1:0]             baud_q, baud_d;
    logic [3:0]                bit_q, bit_d;
    logic [DATA_BITS-1:0]      shift_q, shift_d;
    logic                      par_bad_q, par_bad_d;
    logic                      par_exp;
    logic                      push, frame_err_set;

    logic [DATA_BITS-1:0]      mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]             count_q, count_d;
    logic                      empty, full, pop, write, ov_set, pe_set;
    logic                      pe_q, fe_q, ov_q;

    // Synchroniser resets low so a reset while rx is low cannot fake an idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign par_exp = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q + 1'b1;
        bit_d         = bit_q;
        shift_d       = shift_q;
        par_bad_d     = par_bad_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        unique case (state_q)
            StWaitIdle: begin
                baud_d = '0;
                if (rx_s_q) state_d = StIdle;
            end
            StIdle: begin
                baud_d    = '0;
                bit_d     = '0;
                par_bad_d = 1'b0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (baud_q == HalfLast) begin
                    baud_d  = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (baud_q == BitLast) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (baud_q == BitLast) begin
                    baud_d    = '0;
                    par_bad_d = (rx_s_q != par_exp);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (baud_q == BitLast) begin
                    baud_d = '0;
                    if (!rx_s_q) begin
                        frame_err_set = 1'b1;
                        state_d       = StWaitIdle;
                    end else if (bit_q == StopLast) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StWaitIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StWaitIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign empty  = (count_q == '0);
    assign full   = (count_q == DepthVal);
    assign pop    = bus.rd & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without rd.
    assign ov_set = push & full & ~pop;
    assign write  = push & ~ov_set;
    assign pe_set = push & par_bad_q;

    always_comb begin
        count_d = count_q;
        if (write && !pop) count_d = count_q + 1'b1;
        else if (pop && !write) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (write) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            if (write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            pe_q    <= pe_set | (pe_q & ~bus.error_clear);
            fe_q    <= frame_err_set | (fe_q & ~bus.error_clear);
            ov_q    <= ov_set | (ov_q & ~bus.error_clear);
        end
    end

    assign bus.data          = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.count         = count_q;
    assign bus.empty         = empty;
    assign bus.full          = full;
    assign bus.parity_error  = pe_q;
    assign bus.framing_error = fe_q;
    assign bus.overflow      = ov_q;
    assign bus.interrupt     = (count_q >= IrqVal) | pe_q | fe_q | ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance driven by a bit-banged UART source,
// checked every cycle against a queue model plus literal spot checks.
module tb_uart_rx_fifo;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH_BITS(4)) ifa ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH_BITS(4)) ifb ();

    uart_rx_fifo #(
        .CLOCK_DIV(16), .CLOCK_COUNTER_BITS(4), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH_BITS(4), .IRQ_LEVEL(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    uart_rx_fifo #(
        .CLOCK_DIV(16), .CLOCK_COUNTER_BITS(4), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH_BITS(4), .IRQ_LEVEL(1)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit pea, fea, ova, peb, feb, ovb;
    bit en = 1'b0;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (en) begin
            chk("a_count", ifa.count, qa.size());
            chk("a_empty", ifa.empty, qa.size() == 0);
            chk("a_full", ifa.full, qa.size() == 16);
            chk("a_data", ifa.data, (qa.size() > 0) ? qa[0] : 8'h00);
            chk("a_perr", ifa.parity_error, pea);
            chk("a_ferr", ifa.framing_error, fea);
            chk("a_ovf", ifa.overflow, ova);
            chk("a_irq", ifa.interrupt, (qa.size() >= 1) | pea | fea | ova);
            chk("b_count", ifb.count, qb.size());
            chk("b_data", ifb.data, (qb.size() > 0) ? qb[0] : 8'h00);
            chk("b_perr", ifb.parity_error, peb);
            chk("b_ferr", ifb.framing_error, feb);
            chk("b_irq", ifb.interrupt, (qb.size() >= 1) | peb | feb | ovb);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) ifb.rx = v;
        else ifa.rx = v;
    endtask

    // sel=1 targets the even-parity instance; stop_low holds the stop bit low for that many bits.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_wrong,
                              input int stop_low);
        logic pbit;
        en = 1'b0;
        @(negedge clk);
        set_rx(sel, 1'b0);
        hold(DIV);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            hold(DIV);
        end
        if (sel) begin
            pbit = (^d) ^ par_wrong;
            set_rx(sel, pbit);
            hold(DIV);
        end
        if (stop_low > 0) begin
            set_rx(sel, 1'b0);
            hold(stop_low * DIV);
        end
        set_rx(sel, 1'b1);
        hold(DIV + 4);
        if (!sel) begin
            if (stop_low > 0) fea = 1'b1;
            else if (qa.size() == 16) ova = 1'b1;
            else qa.push_back(d);
        end else begin
            if (stop_low > 0) feb = 1'b1;
            else begin
                if (par_wrong) peb = 1'b1;
                if (qb.size() == 16) ovb = 1'b1;
                else qb.push_back(d);
            end
        end
        en = 1'b1;
    endtask

    task automatic pop(input bit sel);
        @(negedge clk);
        if (sel) begin
            ifb.rd = 1'b1;
            if (qb.size() > 0) void'(qb.pop_front());
        end else begin
            ifa.rd = 1'b1;
            if (qa.size() > 0) void'(qa.pop_front());
        end
        @(negedge clk);
        ifa.rd = 1'b0;
        ifb.rd = 1'b0;
    endtask

    task automatic clear_err(input bit sel);
        @(negedge clk);
        if (sel) begin
            ifb.error_clear = 1'b1;
            peb = 1'b0; feb = 1'b0; ovb = 1'b0;
        end else begin
            ifa.error_clear = 1'b1;
            pea = 1'b0; fea = 1'b0; ova = 1'b0;
        end
        @(negedge clk);
        ifa.error_clear = 1'b0;
        ifb.error_clear = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        qa.delete(); qb.delete();
        pea = 1'b0; fea = 1'b0; ova = 1'b0;
        peb = 1'b0; feb = 1'b0; ovb = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_count", ifa.count, 0);
        chk("rst_empty", ifa.empty, 1);
        chk("rst_full", ifa.full, 0);
        chk("rst_data", ifa.data, 0);
        chk("rst_flags", {ifa.parity_error, ifa.framing_error, ifa.overflow}, 0);
        chk("rst_irq", ifa.interrupt, 0);
        en = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        ifa.rx = 1'b1; ifa.rd = 1'b0; ifa.error_clear = 1'b0;
        ifb.rx = 1'b1; ifb.rd = 1'b0; ifb.error_clear = 1'b0;
        hold(3);
        do_reset();
        hold(4);

        // 8N1 single word, then drain
        send_frame(0, 8'h5A, 0, 0);
        chk("t1_data", ifa.data, 8'h5A);
        chk("t1_count", ifa.count, 1);
        chk("t1_irq", ifa.interrupt, 1);
        pop(0);
        chk("t1_empty", ifa.empty, 1);
        chk("t1_irq_off", ifa.interrupt, 0);
        pop(0);
        chk("t1_rd_empty", ifa.count, 0);

        // even parity, bad parity bit
        send_frame(1, 8'hA5, 1, 0);
        chk("t2_data", ifb.data, 8'hA5);
        chk("t2_perr", ifb.parity_error, 1);
        clear_err(1);
        chk("t2_perr_clr", ifb.parity_error, 0);
        pop(1);
        send_frame(1, 8'h3C, 0, 0);
        chk("t2_good", ifb.data, 8'h3C);
        chk("t2_no_perr", ifb.parity_error, 0);
        pop(1);

        // stop bit held low for three bit times
        send_frame(0, 8'h77, 0, 3);
        chk("t3_ferr", ifa.framing_error, 1);
        chk("t3_count", ifa.count, 0);
        send_frame(0, 8'h33, 0, 0);
        chk("t3_data", ifa.data, 8'h33);
        pop(0);
        clear_err(0);

        // overfill: 17 words into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 0, 0);
        chk("t4_full", ifa.full, 1);
        chk("t4_count", ifa.count, 16);
        chk("t4_ovf", ifa.overflow, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t4_order", ifa.data, i);
            pop(0);
        end
        chk("t4_empty", ifa.empty, 1);
        clear_err(0);

        // 4-cycle low glitch while idle
        @(negedge clk);
        ifa.rx = 1'b0;
        hold(4);
        ifa.rx = 1'b1;
        hold(3 * DIV);
        chk("t5_count", ifa.count, 0);
        chk("t5_flags", {ifa.parity_error, ifa.framing_error, ifa.overflow}, 0);
        send_frame(0, 8'h81, 0, 0);
        chk("t5_data", ifa.data, 8'h81);
        pop(0);

        // reset mid-frame while rx low; remainder of frame must be ignored
        send_frame(0, 8'h11, 0, 0);
        en = 1'b0;
        @(negedge clk);
        ifa.rx = 1'b0;
        hold(4 * DIV);
        do_reset();
        hold(5 * DIV);
        ifa.rx = 1'b1;
        hold(3 * DIV);
        chk("t6_count", ifa.count, 0);
        chk("t6_flags", {ifa.parity_error, ifa.framing_error, ifa.overflow}, 0);
        send_frame(0, 8'hC3, 0, 0);
        chk("t6_data", ifa.data, 8'hC3);
        chk("t6_count1", ifa.count, 1);
        pop(0);
        hold(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
